mmu_walker: RTL

MMU_WALKER -- requirements
Module: mmu_walker

---
 rtl/mmu_walker.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mmu_walker.sv
// Multi-channel Sv39/Sv48 page-table walker with round-robin channel arbitration.
// Define MMU_WALKER_AD_UPDATE_EN to write back A/D bits instead of faulting on them.
module mmu_walker #(
  parameter int NCH    = 2,
  parameter int LEVELS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       page_table_root,
  input  logic [NCH-1:0]    req_valid,
  input  logic [64*NCH-1:0] req_va,
  input  logic [NCH-1:0]    req_st,
  output logic              mem_req_valid,
  output logic              mem_req_store,
  output logic [63:0]       mem_req_addr,
  output logic [63:0]       mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_data,
  output logic [NCH-1:0]    rsp_valid,
  output logic [63:0]       phys_addr,
  output logic              page_fault,
  output logic              page_dirty,
  output logic              page_readable,
  output logic              page_writable,
  output logic              page_executable
);

  localparam int VAW = 12 + 9 * LEVELS;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_AD_WR, S_AD_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      lvl_q, lvl_d;
  logic [CW-1:0]   rr_q, rr_d, act_q, act_d, grant_ch;
  logic            grant_any;
  logic [NCH-1:0]  pend_q, eff_req;
  logic [63:0]     slot_va_q [NCH];
  logic [NCH-1:0]  slot_st_q;
  logic [63:0]     va_q, va_d, base_q, base_d, pte_q, pte_d;
  logic            st_q, st_d;
  logic            mreq_valid_q, mreq_valid_d, mreq_store_q, mreq_store_d;
  logic [63:0]     mreq_addr_q, mreq_addr_d, mreq_data_q, mreq_data_d;
  logic [NCH-1:0]  rsp_valid_q, rsp_valid_d;
  logic [63:0]     pa_q, pa_d;
  logic            fault_q, fault_d, dirty_q, dirty_d, rd_q, rd_d, wr_q, wr_d, ex_q, ex_d;
  logic            walk_fail, va_canon;
  logic [5:0]      lvl_sh;
  logic [8:0]      vpn;
  logic [43:0]     ppn_mask;
  logic [63:0]     pa_mask;
  logic            unused_pte;

  // A request arriving in the same cycle as the slot is granted is consumed by that grant.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
    assign eff_req[gi] = pend_q[gi] | req_valid[gi];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pend_q[gi]    <= 1'b0;
        slot_va_q[gi] <= '0;
        slot_st_q[gi] <= 1'b0;
      end else begin
        if (req_valid[gi]) begin
          slot_va_q[gi] <= req_va[64*gi +: 64];
          slot_st_q[gi] <= req_st[gi];
        end
        if (grant_any && grant_ch == CW'(gi)) pend_q[gi] <= 1'b0;
        else if (req_valid[gi])               pend_q[gi] <= 1'b1;
      end
    end
  end

  // Scan downward so the candidate closest to the pointer wins.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    if (state_q == S_IDLE) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (eff_req[(int'(rr_q) + k) % NCH]) begin
          grant_any = 1'b1;
          grant_ch  = CW'((int'(rr_q) + k) % NCH);
        end
      end
    end
  end

  assign lvl_sh     = 6'(9 * lvl_q);
  assign vpn        = 9'(va_q >> (6'd12 + lvl_sh));
  assign ppn_mask   = (44'd1 << lvl_sh) - 44'd1;
  assign pa_mask    = {8'd0, ppn_mask, 12'd0};
  assign va_canon   = (va_q[63:VAW-1] == '0) || (&va_q[63:VAW-1]);
  assign unused_pte = ^{pte_q[63:54], pte_q[9:8], pte_q[6:4], pte_q[0]};

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    act_d        = act_q;
    rr_d         = rr_q;
    va_d         = va_q;
    st_d         = st_q;
    base_d       = base_q;
    pte_d        = pte_q;
    mreq_valid_d = 1'b0;
    mreq_store_d = 1'b0;
    mreq_addr_d  = mreq_addr_q;
    mreq_data_d  = mreq_data_q;
    rsp_valid_d  = '0;
    pa_d         = '0;
    fault_d      = 1'b0;
    dirty_d      = 1'b0;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ex_d         = 1'b0;
    walk_fail    = 1'b0;
    case (state_q)
      S_IDLE: if (grant_any) begin
        act_d   = grant_ch;
        rr_d    = (int'(grant_ch) == NCH - 1) ? '0 : grant_ch + 1'b1;
        va_d    = req_valid[grant_ch] ? req_va[64*grant_ch +: 64] : slot_va_q[grant_ch];
        st_d    = req_valid[grant_ch] ? req_st[grant_ch] : slot_st_q[grant_ch];
        base_d  = page_table_root;
        lvl_d   = 3'(LEVELS - 1);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!va_canon) walk_fail = 1'b1;
        else begin
          mreq_valid_d = 1'b1;
          mreq_addr_d  = base_q + {52'd0, vpn, 3'b000};
          state_d      = S_WAIT;
        end
      end
      S_WAIT: if (mem_rsp_valid) begin
        pte_d = mem_rsp_data;
        if (!mem_rsp_data[0] || (!mem_rsp_data[1] && mem_rsp_data[2])) walk_fail = 1'b1;
        else if (mem_rsp_data[3:1] == 3'b000) begin
          if (lvl_q == 3'd0) walk_fail = 1'b1;
          else begin
            lvl_d   = lvl_q - 3'd1;
            base_d  = {8'd0, mem_rsp_data[53:10], 12'd0};
            state_d = S_LOAD;
          end
        end else if ((|(mem_rsp_data[53:10] & ppn_mask)) || (st_q && !mem_rsp_data[2])) begin
          walk_fail = 1'b1;
        end else if (!mem_rsp_data[6] || (st_q && !mem_rsp_data[7])) begin
`ifdef MMU_WALKER_AD_UPDATE_EN
          pte_d   = mem_rsp_data | 64'h40 | {56'd0, st_q, 7'd0};
          state_d = S_AD_WR;
`else
          walk_fail = 1'b1;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef MMU_WALKER_AD_UPDATE_EN
      S_AD_WR: begin
        mreq_valid_d = 1'b1;
        mreq_store_d = 1'b1;
        mreq_data_d  = pte_q;
        state_d      = S_AD_WAIT;
      end
      S_AD_WAIT: if (mem_rsp_valid) state_d = S_DONE;
`endif
      S_DONE: begin
        rsp_valid_d[act_q] = 1'b1;
        pa_d    = ({8'd0, pte_q[53:10], 12'd0} & ~pa_mask) | (va_q & pa_mask);
        dirty_d = pte_q[7];
        rd_d    = pte_q[1];
        wr_d    = pte_q[2];
        ex_d    = pte_q[3];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (walk_fail) begin
      rsp_valid_d[act_q] = 1'b1;
      fault_d            = 1'b1;
      state_d            = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;      lvl_q <= '0;        act_q <= '0;       rr_q <= '0;
      va_q <= '0;             st_q <= 1'b0;       base_q <= '0;      pte_q <= '0;
      mreq_valid_q <= 1'b0;   mreq_store_q <= 1'b0;
      mreq_addr_q <= '0;      mreq_data_q <= '0;  rsp_valid_q <= '0; pa_q <= '0;
      fault_q <= 1'b0;        dirty_q <= 1'b0;    rd_q <= 1'b0;      wr_q <= 1'b0;
      ex_q <= 1'b0;
    end else begin
      state_q <= state_d;     lvl_q <= lvl_d;     act_q <= act_d;    rr_q <= rr_d;
      va_q <= va_d;           st_q <= st_d;       base_q <= base_d;  pte_q <= pte_d;
      mreq_valid_q <= mreq_valid_d;               mreq_store_q <= mreq_store_d;
      mreq_addr_q <= mreq_addr_d;                 mreq_data_q <= mreq_data_d;
      rsp_valid_q <= rsp_valid_d;                 pa_q <= pa_d;
      fault_q <= fault_d;     dirty_q <= dirty_d; rd_q <= rd_d;      wr_q <= wr_d;
      ex_q <= ex_d;
    end
  end

  assign mem_req_valid   = mreq_valid_q;
  assign mem_req_store   = mreq_store_q;
  assign mem_req_addr    = mreq_addr_q;
  assign mem_req_data    = mreq_data_q;
  assign rsp_valid       = rsp_valid_q;
  assign phys_addr       = pa_q;
  assign page_fault      = fault_q;
  assign page_dirty      = dirty_q;
  assign page_readable   = rd_q;
  assign page_writable   = wr_q;
  assign page_executable = ex_q;

endmodule
